// File: rtl/adder_pkg.sv
// Shared definitions for the parallel-prefix adder pipeline stages.
// The g/p word layout and skid-buffer state encoding are reused by the tree and sum stages.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] g;
    logic [ADDER_WIDTH-1:0] p;
    logic                   cin;
  } gp_word_t;

  // Encoded as {main valid, skid valid}, so each bit doubles as an entry-valid flag.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/gp_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the outputs,
// skid register absorbs one word of backpressure so in_ready comes straight from a flop.
module gp_skid_buf
  import adder_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] m_q, m_d;
  logic [DW-1:0] s_q, s_d;
  logic          in_xfer;
  logic          out_xfer;

  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = m_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          m_d     = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (out_xfer && in_xfer) begin
          m_d = in_data;
        end else if (out_xfer) begin
          state_d = SKID_EMPTY;
        end else if (in_xfer) begin
          s_d     = in_data;
          state_d = SKID_FULL;
        end
      end
      SKID_FULL: begin
        // Upstream is blocked here, so only the drain into the main register can happen.
        if (out_xfer) begin
          m_d     = s_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

endmodule

// File: rtl/gp_pre_stage.sv
// Front stage of the prefix adders: bitwise generate/propagate with optional
// carry-in fold into bit 0, registered through a skid buffer.
module gp_pre_stage
  import adder_pkg::*;
#(
  parameter int WIDTH    = ADDER_WIDTH,
  parameter bit FOLD_CIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out,
  output logic             cin_out
);

  localparam int DW = 2 * WIDTH + 1;

  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] p_pre;
  logic [DW-1:0]    word_in;
  logic [DW-1:0]    word_out;

  // p stays unfolded because the sum stage needs the raw a^b.
  always_comb begin
    p_pre = a ^ b;
    g_pre = a & b;
    if (FOLD_CIN) begin
      g_pre[0] = g_pre[0] | (p_pre[0] & cin);
    end
  end

  assign word_in = {g_pre, p_pre, cin};

  gp_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (word_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (word_out)
  );

  assign g_out   = word_out[DW-1 -: WIDTH];
  assign p_out   = word_out[WIDTH -: WIDTH];
  assign cin_out = word_out[0];

endmodule

// File: tb/tb_gp_pre_stage.sv
// Directed and randomised checks of gp_pre_stage against a bitwise model and a FIFO scoreboard.
module tb_gp_pre_stage;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_ready, in_ready0;
  logic         out_valid, out_valid0;
  logic [W-1:0] g_out, g_out0;
  logic [W-1:0] p_out, p_out0;
  logic         cin_out, cin_out0;

  int nAsserts = 0;
  int nFails   = 0;

  gp_pre_stage #(.WIDTH(W), .FOLD_CIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .g_out(g_out), .p_out(p_out), .cin_out(cin_out)
  );

  gp_pre_stage #(.WIDTH(W), .FOLD_CIN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready),
    .g_out(g_out0), .p_out(p_out0), .cin_out(cin_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W:0] modelWord(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                              input logic mc);
    logic [W-1:0] mg;
    logic [W-1:0] mp;
    mp = ma ^ mb;
    mg = ma & mb;
    mg[0] = mg[0] | (mp[0] & mc);
    return {mg, mp, mc};
  endfunction

  task automatic checkOutput(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] sa, input logic [W-1:0] sb,
                               input logic sc, input logic r);
    in_valid  = v;
    a         = sa;
    b         = sb;
    cin       = sc;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2*W:0] q[$];
  logic [2*W:0] curWord, prevWord, expWord;
  logic         held;
  logic         irBefore;
  logic         inX, outX;
  logic [W-1:0] ra, rb;
  logic         rc;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
    #3;
    checkOutput("reset_out_valid", {32'd0, out_valid}, 33'd0);
    checkOutput("reset_g", {17'd0, g_out}, 33'd0);
    checkOutput("reset_p", {17'd0, p_out}, 33'd0);
    checkOutput("reset_cin", {32'd0, cin_out}, 33'd0);
    checkOutput("reset_in_ready", {32'd0, in_ready}, 33'd1);
    tick();
    checkOutput("reset_discard", {32'd0, out_valid}, 33'd0);
    rst_n = 1'b1;

    $display("[TB] basic g/p");
    applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    tick();
    checkOutput("t1_valid", {32'd0, out_valid}, 33'd1);
    checkOutput("t1_g", {17'd0, g_out}, 33'h0001);
    checkOutput("t1_p", {17'd0, p_out}, 33'h00FE);
    checkOutput("t1_cin", {32'd0, cin_out}, 33'd0);

    applyStimulus(1'b1, 16'h0001, 16'h0000, 1'b1, 1'b1);
    tick();
    checkOutput("t2_g_fold", {17'd0, g_out}, 33'h0001);
    checkOutput("t2_p_fold", {17'd0, p_out}, 33'h0001);
    checkOutput("t2_cin", {32'd0, cin_out}, 33'd1);
    checkOutput("t2_g_nofold", {17'd0, g_out0}, 33'h0000);
    checkOutput("t2_cin_nofold", {32'd0, cin_out0}, 33'd1);

    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    checkOutput("t2_drain", {32'd0, out_valid}, 33'd0);

    $display("[TB] stall");
    applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick();
    checkOutput("t3_w1_valid", {32'd0, out_valid}, 33'd1);
    checkOutput("t3_w1_ready", {32'd0, in_ready}, 33'd1);
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick();
    checkOutput("t3_full_ready", {32'd0, in_ready}, 33'd0);
    checkOutput("t3_hold_g", {17'd0, g_out}, 33'h0000);
    checkOutput("t3_hold_p", {17'd0, p_out}, 33'hFFFF);
    applyStimulus(1'b1, 16'h1234, 16'h00FF, 1'b0, 1'b0);
    tick();
    checkOutput("t3_hold2_p", {17'd0, p_out}, 33'hFFFF);
    checkOutput("t3_hold2_ready", {32'd0, in_ready}, 33'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("t3_w2_g", {17'd0, g_out}, 33'hFFFF);
    checkOutput("t3_w2_p", {17'd0, p_out}, 33'h0000);
    checkOutput("t3_ready_back", {32'd0, in_ready}, 33'd1);
    checkOutput("t3_w2_valid", {32'd0, out_valid}, 33'd1);
    tick();
    checkOutput("t3_w3_g", {17'd0, g_out}, 33'h0034);
    checkOutput("t3_w3_p", {17'd0, p_out}, 33'h12CB);
    in_valid = 1'b0;
    tick();
    checkOutput("t3_empty", {32'd0, out_valid}, 33'd0);

    $display("[TB] back-to-back");
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      expWord = modelWord(ra, rb, rc);
      applyStimulus(1'b1, ra, rb, rc, 1'b1);
      tick();
      checkOutput("t4_valid", {32'd0, out_valid}, 33'd1);
      checkOutput("t4_word", {g_out, p_out, cin_out}, expWord);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("t4_empty", {32'd0, out_valid}, 33'd0);

    $display("[TB] random handshake");
    held = 1'b0;
    prevWord = '0;
    for (int i = 0; i < 10000; i++) begin
      curWord = {g_out, p_out, cin_out};
      checkOutput("t5_out_valid", {32'd0, out_valid}, {32'd0, q.size() > 0});
      checkOutput("t5_in_ready", {32'd0, in_ready}, {32'd0, q.size() < 2});
      if (held) checkOutput("t5_stable", curWord, prevWord);
      irBefore = in_ready;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      applyStimulus(1'($urandom), ra, rb, rc, ($urandom_range(0, 3) != 0));
      #1;
      checkOutput("t5_ready_comb", {32'd0, in_ready}, {32'd0, irBefore});
      inX  = in_valid & in_ready;
      outX = out_valid & out_ready;
      if (outX) begin
        if (q.size() > 0) checkOutput("t5_order", curWord, q.pop_front());
        else checkOutput("t5_spurious", {32'd0, outX}, 33'd0);
      end
      if (inX) q.push_back(modelWord(ra, rb, rc));
      held = out_valid & ~out_ready;
      prevWord = curWord;
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("t5_drained", {32'd0, out_valid}, 33'd0);

    $display("[TB] reset in FULL");
    applyStimulus(1'b1, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h00FF, 16'h00F0, 1'b1, 1'b0);
    tick();
    checkOutput("t6_full", {32'd0, in_ready}, 33'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {32'd0, out_valid}, 33'd0);
    checkOutput("t6_rst_g", {17'd0, g_out}, 33'd0);
    checkOutput("t6_rst_p", {17'd0, p_out}, 33'd0);
    checkOutput("t6_rst_ready", {32'd0, in_ready}, 33'd1);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h0F0F, 16'h00FF, 1'b1, 1'b1);
    tick();
    checkOutput("t6_new_valid", {32'd0, out_valid}, 33'd1);
    checkOutput("t6_new_g", {17'd0, g_out}, 33'h000F);
    checkOutput("t6_new_p", {17'd0, p_out}, 33'h0FF0);
    checkOutput("t6_new_cin", {32'd0, cin_out}, 33'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/gp_pre_stage.md
Name: gp_pre_stage

Overview:
- Registered pre-processing stage at the front of the parallel-prefix adders.
- Accepts operand pairs A, B and carry-in over a valid/ready handshake. Computes bitwise generate (a&b) and propagate (a^b), optionally folding carry-in into bit 0.
- Presents the registered g/p vectors to the prefix tree of group g/p combine cells.
- A 2-entry skid buffer gives full throughput with registered backpressure.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- FOLD_CIN, 1, 1: g_out[0] = a0&b0 | (a0^b0)&cin; 0: g_out[0] = a0&b0, with cin passed through unchanged.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand word valid
- in_ready  output  1  stage can accept a word
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  g/p word valid
- out_ready  input  1  prefix tree accepts word
- g_out  output  WIDTH  bitwise generate (bit 0 cin-folded per FOLD_CIN)
- p_out  output  WIDTH  bitwise propagate a^b (never cin-folded; used later for sum = p ^ carry)
- cin_out  output  1  registered cin, kept for the sum stage

Behaviour:
- Single clock domain: clk, async active-low reset rst_n.
- **Reset values:** out_valid=0, g_out=0, p_out=0, cin_out=0, skid entry invalid, in_ready=1.
  - Transfers presented while rst_n=0 are discarded.
- **Handshake:** in-transfer when in_valid&in_ready at a rising clk edge; out-transfer when out_valid&out_ready.
  - out_valid, once high, holds until the out-transfer.
  - g_out/p_out/cin_out stay stable while out_valid=1 and out_ready=0.
- **Latency:** 1 cycle from in-transfer to out_valid when the output register is empty or draining.
- **Throughput:** one word per cycle while out_ready=1.
- **Storage:** main register M (drives outputs) and skid register S.
  - in_ready = ~S.valid, taken directly from a flop with no combinational path from out_ready.
- **State** = {M.valid, S.valid}: EMPTY(0,0), ONE(1,0), FULL(1,1). There is no (0,1) state.
  - EMPTY: in-transfer -> load M, go to ONE.
  - ONE, out-transfer and in-transfer -> reload M, stay in ONE.
  - ONE, out-transfer only -> EMPTY.
  - ONE, in-transfer only (out_ready=0) -> load S, go to FULL.
  - ONE, neither -> hold.
  - FULL: in_ready=0. On out-transfer -> M<=S, S invalid, go to ONE. Otherwise hold.
- **Arithmetic:** purely bitwise, no carries.
  - Computed from a/b/cin before registering, so the S and M contents are both already-processed words.
- **Ordering:** strict FIFO; no word is dropped or duplicated.
- **Reset mid-operation:** both entries invalidated immediately (asynchronous). Outputs go to reset values in the same cycle; the words held are lost.
- **Simultaneous events:**
  - In FULL, out_ready=1 and in_valid=1: no in-transfer (in_ready=0); the next cycle is ONE with in_ready=1.
  - in_valid deasserted without a transfer is permitted (no valid-stability requirement on the upstream side).

Decomposition:
- Shared package (adder_pkg), holding:
  - ADDER_WIDTH default constant.
  - typedef gp_word_t {logic [W-1:0] g; logic [W-1:0] p; logic cin;}, used by the prefix-tree stages.
- One sub-module is natural: gp_skid_buf.
  - Generic 2-entry valid/ready skid buffer parameterised by data width (2*WIDTH+1).
  - Reusable by the later pipelined prefix-tree and sum stages.
- gp_pre_stage = combinational g/p/fold logic + one gp_skid_buf instance.

Test Plan:
1. WIDTH=16, FOLD_CIN=1, out_ready=1: a=0x00FF, b=0x0001, cin=0 -> next cycle out_valid=1, g_out=0x0001, p_out=0x00FE, cin_out=0.
2. Cin fold: a=0x0001, b=0x0000, cin=1 -> g_out=0x0001, p_out=0x0001, cin_out=1.
   - Same stimulus with FOLD_CIN=0 -> g_out=0x0000.
3. Stall: out_ready=0, send W1 (a=0xAAAA, b=0x5555) then W2 (a=0xFFFF, b=0xFFFF).
   - in_ready drops to 0 after W2; outputs hold g=0x0000, p=0xFFFF.
   - Raise out_ready -> W1 out, then W2 out with g=0xFFFF, p=0x0000.
   - in_ready returns to 1 after the first out-transfer.
4. Back-to-back: 100 random words with out_ready=1 -> 100 outputs in order, 1 per cycle, 1-cycle latency, checked against a bitwise model.
5. Random out_ready/in_valid for 10k cycles -> scoreboard FIFO order.
   - No loss or duplication; outputs stable during stalls; in_ready never depends combinationally on out_ready.
6. Reset in FULL state: assert rst_n=0 mid-cycle -> out_valid=0 and g_out=p_out=0 immediately, in_ready=1.
   - After release, the first new word emerges with 1-cycle latency.
